score_ctrl: RTL and testbench
=============================

# score_ctrl

Game score controller that sequences the score datapath. It counts point events during a game, saturates at the two-digit display limit, and tracks a high score. It also flashes the display when a game ends with a new record. It sits between game logic, which supplies the start, point and game-over pulses, and the score-to-glyph converter, which consumes the 10-bit display value.

## Interface

Parameters:
- `MAX_SCORE`, 99: saturation limit. Must be ≤ 99 so the glyph converter sees two decimal digits.
- `FLASH_CYCLES`, 25_000_000: clock cycles between blank toggles in OVER (0.25 s at 100 MHz).
- `FLASH_TOGGLES`, 6: number of blank toggles in OVER. Must be even and ≥ 2.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle pulse that begins a game.
- `point` in 1: one-cycle pulse that adds one point.
- `game_over` in 1: one-cycle pulse that ends the game.
- `score` out 10: current or last-game score, 0..MAX_SCORE.
- `hiscore` out 10: best score since reset.
- `disp` out 10: value driven to the glyph converter.
- `blank` out 1: when 1, the display shows nothing (flash phase).
- `new_hi` out 1: the last game set a new high score.
- `state` out 2: 0 = IDLE, 1 = PLAY, 2 = OVER.

## Operation

- State machine: IDLE → PLAY on `start`. PLAY → OVER on `game_over`. OVER → IDLE when the OVER timer expires. Encoding 3 is unreachable and recovers to IDLE.
- **IDLE**
  - `score` holds the last game's value.
  - `point` and `game_over` are ignored.
  - `start` clears `score` to 0 and `new_hi` to 0 on the same edge as the move to PLAY.
- **PLAY**
  - `point`: `score` ← min(`score` + 1, MAX_SCORE). At MAX_SCORE, further points are dropped.
  - `start` is ignored.
  - `point` and `game_over` in the same cycle: the point is counted, then the move to OVER happens on the same edge. Define next_score = the post-increment value.
  - On the PLAY → OVER edge, if next_score > `hiscore`: `hiscore` ← next_score and `new_hi` ← 1. An equal score is not a new high.
- **OVER**
  - A flash counter counts FLASH_CYCLES per phase.
  - If `new_hi` = 1:
    - `blank` starts at 0 on the first OVER cycle.
    - `blank` toggles each time the counter wraps.
    - After FLASH_TOGGLES toggles, `blank` = 0 and the state moves to IDLE on that same edge.
  - If `new_hi` = 0: `blank` stays 0 and the state moves to IDLE after the same total duration.
  - All inputs are ignored in OVER.
- **`disp` selection**
  - `score` in PLAY and OVER.
  - `hiscore` in IDLE.
- Arithmetic is 10-bit unsigned with no wrap, enforced by saturation. The counter is wide enough for FLASH_CYCLES − 1.

## Timing

- All outputs are registered. An input pulse at edge N is visible on the outputs after edge N.
  - `point` → `score` updates with 1-cycle latency.
  - `game_over` → `state` = OVER and `hiscore`/`new_hi` update with 1-cycle latency.
- OVER lasts exactly FLASH_CYCLES × FLASH_TOGGLES cycles.
- **Reset values:** `state` = IDLE, `score` = 0, `hiscore` = 0, `disp` = 0, `blank` = 0, `new_hi` = 0, flash counter = 0.
- **Reset priority:** `rst` overrides every input in every state, including mid-flash and mid-game, and clears `hiscore`.
- `start` held high for several cycles in IDLE starts exactly one game. Later cycles land in PLAY, where `start` is ignored.

## Configuration

Macro `SCORE_CTRL_HISCORE_EN`.

- **Defined:** high-score tracking, new-record flashing, and showing `hiscore` on `disp` in IDLE, all as described above.
- **Undefined:**
  - `hiscore` is tied to 0 and `new_hi` is tied to 0.
  - `blank` is always 0.
  - OVER still lasts FLASH_CYCLES × FLASH_TOGGLES cycles.
  - `disp` = `score` in all states.
  - No high-score register or comparator is synthesized.

## Test plan

All scenarios use the macro defined, FLASH_CYCLES = 4 and FLASH_TOGGLES = 4, unless stated otherwise.

1. **Reset and IDLE filtering:** reset, then pulse `point` ×3 in IDLE → `score` = 0, `state` = 0, `disp` = 0, `blank` = 0.
2. **Scoring and new record:** `start`, 5 × `point`, then `game_over` → `score` = 5. The cycle after `game_over`: `state` = 2, `hiscore` = 5, `new_hi` = 1. `blank` pattern over 16 cycles is 0000 1111 0000 1111, then `state` = 0 and `disp` = 5.
3. **Saturation:** `start`, then 120 × `point` → `score` = 99. The next `point` leaves 99.
4. **Simultaneous pulses:** `start`, 2 × `point`, then `point` and `game_over` in the same cycle with prior `hiscore` = 2 → `score` = 3, `hiscore` = 3, `new_hi` = 1.
5. **Non-record game:** with `hiscore` = 5, play a game ending at 5 → `new_hi` = 0, `blank` stays 0 for all 16 OVER cycles, `hiscore` = 5.
6. **Mid-flash reset and macro-off build:**
   - Assert `rst` on OVER cycle 6 → all outputs at reset values on the next cycle.
   - With the macro undefined, scenario 2 → `hiscore` = 0, `new_hi` = 0, `blank` = 0, `disp` = 5 in IDLE.

Source files
------------

// File: rtl/score_ctrl.sv
// score_ctrl: game score sequencer.
// Counts point events during a game with saturation at MAX_SCORE, keeps the
// best score since reset, and flashes the display for a new record while the
// post-game OVER phase runs.
// Optional feature macro: SCORE_CTRL_HISCORE_EN enables high-score tracking,
// record flashing and showing the high score on disp while idle.
module score_ctrl #(
    parameter int MAX_SCORE     = 99,
    parameter int FLASH_CYCLES  = 25_000_000,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       point,
    input  logic       game_over,
    output logic [9:0] score,
    output logic [9:0] hiscore,
    output logic [9:0] disp,
    output logic       blank,
    output logic       new_hi,
    output logic [1:0] state
);

    localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int TOG_W = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(FLASH_TOGGLES - 1);
    localparam logic [9:0]       SCORE_LIM  = 10'(MAX_SCORE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [9:0]       r_score, w_score_nxt;
    logic [9:0]       r_disp,  w_disp_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [TOG_W-1:0] r_tog,   w_tog_nxt;
    logic             r_blank, w_blank_nxt;
`ifdef SCORE_CTRL_HISCORE_EN
    logic [9:0]       r_hiscore, w_hi_nxt;
    logic             r_new_hi,  w_new_hi_nxt;
`endif

    // Add one point, holding at the display limit instead of wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v < SCORE_LIM) ? v + 10'd1 : v;
    endfunction

    // Register all state and outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_score   <= '0;
            r_disp    <= '0;
            r_cnt     <= '0;
            r_tog     <= '0;
            r_blank   <= 1'b0;
`ifdef SCORE_CTRL_HISCORE_EN
            r_hiscore <= '0;
            r_new_hi  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_score   <= w_score_nxt;
            r_disp    <= w_disp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tog     <= w_tog_nxt;
            r_blank   <= w_blank_nxt;
`ifdef SCORE_CTRL_HISCORE_EN
            r_hiscore <= w_hi_nxt;
            r_new_hi  <= w_new_hi_nxt;
`endif
        end
    end

    // Next-state, scoring, record detection and flash timing.
    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_cnt_nxt    = r_cnt;
        w_tog_nxt    = r_tog;
        w_blank_nxt  = r_blank;
`ifdef SCORE_CTRL_HISCORE_EN
        w_hi_nxt     = r_hiscore;
        w_new_hi_nxt = r_new_hi;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_PLAY;
                    w_score_nxt  = '0;
`ifdef SCORE_CTRL_HISCORE_EN
                    w_new_hi_nxt = 1'b0;
`endif
                end
            end
            S_PLAY: begin
                if (point) begin
                    w_score_nxt = sat_inc(r_score);
                end
                if (game_over) begin
                    // The flash phase always begins unblanked with fresh counters.
                    w_state_nxt = S_OVER;
                    w_cnt_nxt   = '0;
                    w_tog_nxt   = '0;
                    w_blank_nxt = 1'b0;
`ifdef SCORE_CTRL_HISCORE_EN
                    if (w_score_nxt > r_hiscore) begin
                        w_hi_nxt     = w_score_nxt;
                        w_new_hi_nxt = 1'b1;
                    end
`endif
                end
            end
            S_OVER: begin
                if (r_cnt == CNT_MAX) begin
                    w_cnt_nxt = '0;
                    if (r_tog == TOG_LAST) begin
                        w_tog_nxt   = '0;
                        w_blank_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_tog_nxt = r_tog + 1'b1;
`ifdef SCORE_CTRL_HISCORE_EN
                        w_blank_nxt = r_new_hi ? ~r_blank : 1'b0;
`else
                        w_blank_nxt = 1'b0;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                // Unused encoding falls back to idle.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tog_nxt   = '0;
                w_blank_nxt = 1'b0;
            end
        endcase
`ifdef SCORE_CTRL_HISCORE_EN
        w_disp_nxt = (w_state_nxt == S_IDLE) ? w_hi_nxt : w_score_nxt;
`else
        w_disp_nxt = w_score_nxt;
`endif
    end

    assign score = r_score;
    assign disp  = r_disp;
    assign blank = r_blank;
    assign state = r_state;
`ifdef SCORE_CTRL_HISCORE_EN
    assign hiscore = r_hiscore;
    assign new_hi  = r_new_hi;
`else
    assign hiscore = '0;
    assign new_hi  = 1'b0;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: directed scenarios followed by random
// pulses, each checked against a cycle-count based reference model.
module tb_score_ctrl;

    localparam int MAXS = 99;
    localparam int FC   = 4;
    localparam int FT   = 4;
`ifdef SCORE_CTRL_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, point = 1'b0, game_over = 1'b0;
    logic [9:0] score, hiscore, disp;
    logic       blank, new_hi;
    logic [1:0] state;

    score_ctrl #(.MAX_SCORE(MAXS), .FLASH_CYCLES(FC), .FLASH_TOGGLES(FT)) dut (
        .clk(clk), .rst(rst), .start(start), .point(point), .game_over(game_over),
        .score(score), .hiscore(hiscore), .disp(disp), .blank(blank),
        .new_hi(new_hi), .state(state)
    );

    always #5 clk = ~clk;

    // Expected output bundle: {state, score, hiscore, disp, blank, new_hi}
    typedef logic [33:0] obs_t;
    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    // Reference model: game phase plus number of elapsed OVER cycles.
    int m_state = 0, m_score = 0, m_hi = 0, m_newhi = 0, m_el = 0;

    function automatic obs_t model_obs();
        int b, d;
        b = (m_state == 2 && HI_EN && m_newhi == 1) ? ((m_el / FC) % 2) : 0;
        d = (HI_EN && m_state == 0) ? m_hi : m_score;
        return {2'(m_state), 10'(m_score), 10'(m_hi), 10'(d), 1'(b), 1'(m_newhi)};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input bit g);
        if (r) begin
            m_state = 0; m_score = 0; m_hi = 0; m_newhi = 0; m_el = 0;
        end else if (m_state == 0) begin
            if (s) begin
                m_state = 1; m_score = 0; m_newhi = 0;
            end
        end else if (m_state == 1) begin
            if (p && m_score < MAXS) m_score = m_score + 1;
            if (g) begin
                m_state = 2; m_el = 0;
                if (HI_EN && m_score > m_hi) begin
                    m_hi = m_score; m_newhi = 1;
                end
            end
        end else begin
            m_el = m_el + 1;
            if (m_el == FC * FT) m_state = 0;
        end
    endtask

    // Drive one cycle of inputs, then record the expected post-edge outputs.
    task automatic cyc(input bit r, input bit s, input bit p, input bit g);
        rst = r; start = s; point = p; game_over = g;
        @(posedge clk);
        model_step(r, s, p, g);
        exp_q.push_back(model_obs());
        #1;
        rst = 1'b0; start = 1'b0; point = 1'b0; game_over = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic game(input int pts, input bit last_with_go);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < pts; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, last_with_go, 1);
    endtask

    // Monitor: every cycle the DUT presents a registered result; compare it.
    always @(negedge clk) begin
        obs_t e, a;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, score, hiscore, disp, blank, new_hi};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got state=%0d score=%0d hi=%0d disp=%0d blank=%0b new_hi=%0b, expected state=%0d score=%0d hi=%0d disp=%0d blank=%0b new_hi=%0b",
                         cyc_no, a[33:32], a[31:22], a[21:12], a[11:2], a[1], a[0],
                         e[33:32], e[31:22], e[21:12], e[11:2], e[1], e[0]);
            end
        end
    end

    initial begin
        #1;
        // Reset and IDLE filtering
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        // Scoring and new record, full flash
        game(5, 1'b0); idle(20);
        // Non-record game ending at 5
        game(5, 1'b0); idle(20);
        // Saturation: 120 points plus one more, then end
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 121; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1); idle(20);
        // Simultaneous point and game_over with prior high score 2
        cyc(1, 0, 0, 0);
        game(2, 1'b0); idle(20);
        game(2, 1'b1); idle(20);
        // Mid-flash reset on OVER cycle 6
        game(6, 1'b0); idle(5);
        cyc(1, 0, 0, 0); idle(3);
        // start held for several cycles starts one game
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 1); idle(20);
        // Random pulses
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
        end
        idle(2);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
